// File: rtl/decode_queue.sv
// Buffered RV32I decode stage: decodes {pc, inst} at enqueue time into a DEPTH-entry FIFO feeding execute.
// Define RV32M_EN to decode the M extension (OP with funct7=0x01); otherwise those encodings are illegal.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_alu_op,
    output logic [4:0]       out_mem_op,
    output logic             out_wb_en,
    output logic             out_is_branch,
    output logic             out_is_jump,
    output logic             out_illegal,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
`ifdef RV32M_EN
    localparam int ALU_W = 5;
`else
    localparam int ALU_W = 4;
`endif

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_CSRSET = 5'd10;
    localparam logic [4:0] ALU_CSRCLR = 5'd11;

    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [XLEN-1:0]  imm;
        logic [ALU_W-1:0] aluOp;
        logic [4:0]       memOp;
        logic             wbEn;
        logic             isBranch;
        logic             isJump;
        logic             illegal;
    } bundle_t;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Shared funct3 -> ALU mapping for OP and OP_IMM; alt selects SUB/SRA.
    function automatic logic [4:0] baseAlu(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_immI;
    logic [XLEN-1:0] w_immS;
    logic [XLEN-1:0] w_immB;
    logic [XLEN-1:0] w_immU;
    logic [XLEN-1:0] w_immJ;
    logic [XLEN-1:0] w_shamt;
    logic [XLEN-1:0] w_zimm;
    bundle_t         w_dec;
    logic            w_push;
    logic            w_pop;

    assign w_opcode = in_inst[6:0];
    assign w_funct3 = in_inst[14:12];
    assign w_funct7 = in_inst[31:25];

    assign w_immI  = sext({{20{in_inst[31]}}, in_inst[31:20]});
    assign w_immS  = sext({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
    assign w_immB  = sext({{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0});
    assign w_immU  = sext({in_inst[31:12], 12'b0});
    assign w_immJ  = sext({{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0});
    assign w_shamt = XLEN'(in_inst[24:20]);
    assign w_zimm  = XLEN'(in_inst[19:15]);

    always_comb begin
        w_dec          = '0;
        w_dec.pc       = in_pc;
        w_dec.rd       = in_inst[11:7];
        w_dec.rs1      = in_inst[19:15];
        w_dec.rs2      = in_inst[24:20];
        w_dec.aluOp    = ALU_W'(ALU_ADD);
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_dec.imm  = w_immU;
                w_dec.wbEn = 1'b1;
            end
            OPC_JAL: begin
                w_dec.imm    = w_immJ;
                w_dec.isJump = 1'b1;
                w_dec.wbEn   = 1'b1;
            end
            OPC_JALR: begin
                w_dec.imm    = w_immI;
                w_dec.isJump = 1'b1;
                w_dec.wbEn   = 1'b1;
            end
            OPC_BRANCH: begin
                w_dec.imm      = w_immB;
                w_dec.isBranch = 1'b1;
                case (w_funct3)
                    3'd0, 3'd1: w_dec.aluOp   = ALU_W'(ALU_SUB);
                    3'd4, 3'd5: w_dec.aluOp   = ALU_W'(ALU_SLT);
                    3'd6, 3'd7: w_dec.aluOp   = ALU_W'(ALU_SLTU);
                    default:    w_dec.illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_dec.imm = w_immI;
                if (w_funct3 == 3'd3 || w_funct3 == 3'd6 || w_funct3 == 3'd7) begin
                    w_dec.illegal = 1'b1;
                end else begin
                    w_dec.memOp = {MEM_READ, ~w_funct3[2], w_funct3[1:0]};
                    w_dec.wbEn  = 1'b1;
                end
            end
            OPC_STORE: begin
                w_dec.imm = w_immS;
                if (w_funct3 > 3'd2) begin
                    w_dec.illegal = 1'b1;
                end else begin
                    w_dec.memOp = {MEM_WRITE, 1'b0, w_funct3[1:0]};
                end
            end
            OPC_OPIMM: begin
                w_dec.imm   = w_immI;
                w_dec.wbEn  = 1'b1;
                w_dec.aluOp = ALU_W'(baseAlu(w_funct3, 1'b0));
                // Shift immediates carry funct7 in the upper bits, so only the shamt is the operand.
                if (w_funct3 == 3'd1) begin
                    w_dec.imm = w_shamt;
                    if (w_funct7 != 7'h00) w_dec.illegal = 1'b1;
                end else if (w_funct3 == 3'd5) begin
                    w_dec.imm = w_shamt;
                    if (w_funct7 == 7'h20)      w_dec.aluOp   = ALU_W'(ALU_SRA);
                    else if (w_funct7 != 7'h00) w_dec.illegal = 1'b1;
                end
            end
            OPC_OP: begin
                w_dec.wbEn = 1'b1;
                if (w_funct7 == 7'h00 || w_funct7 == 7'h20) begin
                    w_dec.aluOp = ALU_W'(baseAlu(w_funct3, w_funct7[5]));
`ifdef RV32M_EN
                end else if (w_funct7 == 7'h01) begin
                    w_dec.aluOp = {2'b10, w_funct3};
`endif
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                w_dec.imm = w_funct3[2] ? w_zimm : w_immI;
                case (w_funct3[1:0])
                    2'd2:    w_dec.aluOp = ALU_W'(ALU_CSRSET);
                    2'd3:    w_dec.aluOp = ALU_W'(ALU_CSRCLR);
                    default: w_dec.aluOp = ALU_W'(ALU_ADD);
                endcase
                w_dec.wbEn = (w_funct3[1:0] != 2'd0);
            end
            default: w_dec.illegal = 1'b1;
        endcase

        // Illegal entries travel down the pipe as inert bubbles that only raise the trap flag.
        if (w_dec.illegal) begin
            w_dec.aluOp    = ALU_W'(ALU_ADD);
            w_dec.memOp    = '0;
            w_dec.wbEn     = 1'b0;
            w_dec.isBranch = 1'b0;
            w_dec.isJump   = 1'b0;
        end
    end

    bundle_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= w_dec;
                r_wrPtr        <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_pc        = r_mem[r_rdPtr].pc;
    assign out_rd        = r_mem[r_rdPtr].rd;
    assign out_rs1       = r_mem[r_rdPtr].rs1;
    assign out_rs2       = r_mem[r_rdPtr].rs2;
    assign out_imm       = r_mem[r_rdPtr].imm;
    assign out_alu_op    = 5'(r_mem[r_rdPtr].aluOp);
    assign out_mem_op    = r_mem[r_rdPtr].memOp;
    assign out_wb_en     = r_mem[r_rdPtr].wbEn;
    assign out_is_branch = r_mem[r_rdPtr].isBranch;
    assign out_is_jump   = r_mem[r_rdPtr].isJump;
    assign out_illegal   = r_mem[r_rdPtr].illegal;
    assign count         = r_count;

endmodule
